// File: rtl/inst_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_pkg
//   Shared definitions for the instruction fetch controller: fetch FSM state
//   encoding, default widths, the default "long instruction" opcode bit, and a
//   helper that tells whether the memory port is free (no read in flight).
// -----------------------------------------------------------------------------
package inst_fetch_ctrl_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int LONG_BIT_DEF = 7;

    typedef enum logic [2:0] {
        OP_REQ   = 3'd0,  // present pc to memory
        OP_WAIT  = 3'd1,  // opcode byte arrives on mem_dout
        IMM_REQ  = 3'd2,  // present pc+1 to memory
        IMM_WAIT = 3'd3,  // immediate byte arrives on mem_dout
        OUT      = 3'd4   // instruction offered to decode
    } fetch_state_t;

    // The port may be lent to another master only in the request states:
    // in those cycles no read issued on the previous edge is still pending.
    function automatic logic port_free(input fetch_state_t s);
        return (s == OP_REQ) || (s == IMM_REQ);
    endfunction

endpackage

// File: rtl/ifetch_ld_arb.sv
// -----------------------------------------------------------------------------
// ifetch_ld_arb
//   Program-loader arbitration for instruction memory port A. Present only when
//   LOADER_PORT_EN is defined; the default build leaves this file empty.
//   A loader write wins the port whenever the fetch FSM has no read in flight;
//   on a grant the loader address/data drive the port and the fetch stalls.
// Ports:
//   rst_n       in   asynchronous active-low reset (blocks grants while held)
//   port_free   in   fetch FSM is in a request state
//   fetch_addr  in   address the fetch FSM wants this cycle
//   ld_req      in   loader write request
//   ld_addr     in   loader write address
//   ld_data     in   loader write data
//   ld_gnt      out  write performed this cycle (also the fetch stall)
//   mem_addr    out  port A address
//   mem_we      out  port A write enable
//   mem_din     out  port A write data
// -----------------------------------------------------------------------------
`ifdef LOADER_PORT_EN
module ifetch_ld_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              rst_n,
    input  logic              port_free,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din
);

    // No write may reach the memory while the controller is held in reset.
    assign ld_gnt   = ld_req & port_free & rst_n;
    assign mem_addr = ld_gnt ? ld_addr : fetch_addr;
    assign mem_we   = ld_gnt;
    assign mem_din  = ld_gnt ? ld_data : '0;

endmodule
`endif

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//   Instruction fetch controller for the 8-bit CPU. Owns the PC, drives the
//   synchronous instruction memory (1-cycle read latency) and assembles 1- or
//   2-byte instructions (opcode, optional immediate), which it offers to decode
//   over a valid/ready handshake. Handles branch redirects and a level halt.
//   Optional feature macro: LOADER_PORT_EN adds a program-loader write path
//   arbitrated onto the same memory port (see ifetch_ld_arb).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ld_req/addr/data      [LOADER_PORT_EN] loader write request
//   ld_gnt                [LOADER_PORT_EN] loader write performed this cycle
//   mem_addr/we/din       memory port A controls (combinational)
//   mem_dout              memory read data, valid one cycle after mem_addr
//   redirect, redirect_pc branch taken and its target
//   halt                  freeze fetch at the next instruction boundary
//   inst_valid/ready      decode handshake
//   inst_op/imm/len/pc    instruction bytes, length flag, opcode address
// -----------------------------------------------------------------------------
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                LONG_BIT = LONG_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef LOADER_PORT_EN
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_gnt,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_op,
    output logic [DATA_W-1:0] inst_imm,
    output logic              inst_len,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam logic [ADDR_W-1:0] STEP1 = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(2);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [DATA_W-1:0] op_nxt, imm_nxt;
    logic              len_nxt;
    logic [ADDR_W-1:0] ipc_nxt;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;

    // The immediate sits at pc+1; the sum wraps naturally at 2^ADDR_W.
    assign fetch_addr = (state == IMM_REQ) ? (pc + STEP1) : pc;
    assign inst_valid = (state == OUT);

`ifdef LOADER_PORT_EN
    ifetch_ld_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ld_arb (
        .rst_n      (rst_n),
        .port_free  (port_free(state)),
        .fetch_addr (fetch_addr),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_gnt     (ld_gnt),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_din    (mem_din)
    );
    // A granted write uses the port this cycle, so the request state repeats.
    assign stall = ld_gnt;
`else
    assign mem_addr = fetch_addr;
    assign mem_we   = 1'b0;
    assign mem_din  = '0;
    assign stall    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state / capture logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_nxt = state;
        pc_nxt    = pc;
        op_nxt    = inst_op;
        imm_nxt   = inst_imm;
        len_nxt   = inst_len;
        ipc_nxt   = inst_pc;

        unique case (state)
            OP_REQ: begin
                if (!halt && !stall) state_nxt = OP_WAIT;
            end
            OP_WAIT: begin
                op_nxt    = mem_dout;
                ipc_nxt   = pc;
                len_nxt   = mem_dout[LONG_BIT];
                imm_nxt   = '0;
                state_nxt = mem_dout[LONG_BIT] ? IMM_REQ : OUT;
            end
            IMM_REQ: begin
                if (!stall) state_nxt = IMM_WAIT;
            end
            IMM_WAIT: begin
                imm_nxt   = mem_dout;
                state_nxt = OUT;
            end
            OUT: begin
                if (inst_ready) begin
                    pc_nxt    = pc + (inst_len ? STEP2 : STEP1);
                    state_nxt = OP_REQ;
                end
            end
            default: state_nxt = OP_REQ;
        endcase

        // A redirect overrides the sequential pc and drops any partial fetch.
        // A handshake in the same cycle still completes (decode saw it), but
        // the next fetch starts at the target.
        if (redirect) begin
            pc_nxt    = redirect_pc;
            state_nxt = OP_REQ;
        end
    end

    // -------------------------------------------------------------------------
    // State, PC and instruction registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OP_REQ;
            pc       <= RESET_PC;
            inst_op  <= '0;
            inst_imm <= '0;
            inst_len <= 1'b0;
            inst_pc  <= RESET_PC;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            state    <= state_nxt;
            pc       <= pc_nxt;
            inst_op  <= op_nxt;
            inst_imm <= imm_nxt;
            inst_len <= len_nxt;
            inst_pc  <= ipc_nxt;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//   Self-checking bench for inst_fetch_ctrl with a behavioural synchronous
//   instruction memory. Directed table + corner sequences, then randomized
//   ready/redirect traffic checked against an instruction-level model.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halt;
    logic       inst_valid;
    logic       inst_ready;
    logic [7:0] inst_op;
    logic [7:0] inst_imm;
    logic       inst_len;
    logic [7:0] inst_pc;
`ifdef LOADER_PORT_EN
    logic       ld_req;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_gnt;
`endif

    int checks = 0;
    int errors = 0;

    inst_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef LOADER_PORT_EN
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_gnt      (ld_gnt),
`endif
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_din     (mem_din),
        .mem_dout    (mem_dout),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_op     (inst_op),
        .inst_imm    (inst_imm),
        .inst_len    (inst_len),
        .inst_pc     (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction memory -----------------------------------
    logic [7:0] image [256];
`ifdef LOADER_PORT_EN
    logic [7:0] ldmem   [256];
    bit         ldvalid [256];
`endif

    function automatic logic [7:0] mem_rd(input logic [7:0] a);
`ifdef LOADER_PORT_EN
        if (ldvalid[a]) return ldmem[a];
`endif
        return image[a];
    endfunction

    always @(posedge clk) begin
        mem_dout <= mem_rd(mem_addr);
`ifdef LOADER_PORT_EN
        if (mem_we) begin
            ldmem[mem_addr]   <= mem_din;
            ldvalid[mem_addr] <= 1'b1;
        end
`endif
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cyc++;
            if (inst_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL valid_timeout: no inst_valid within %0d cycles", max_cyc);
    endtask

    task automatic expect_inst(input string tag, input int cyc, input int lat,
                               input logic [7:0] pc, input logic [7:0] op,
                               input logic [7:0] imm, input logic len);
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_pc"},  inst_pc, pc);
        check({tag, "_op"},  inst_op, op);
        check({tag, "_imm"}, inst_imm, imm);
        check({tag, "_len"}, inst_len, len);
    endtask

    typedef struct {
        logic [7:0] pc;
        logic [7:0] op;
        logic [7:0] imm;
        logic       len;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    // ---------------- random-phase model state -----------------------------
    logic [7:0] m_pc;
    logic [7:0] e_op, e_imm;
    logic       e_len;
    bit         seen;
    int         since;
    bit         hs;

    initial begin
        int cyc;
        logic [7:0] s_op, s_pc, s_addr;

        // Memory image: fixed program in the low bytes and at FF, random elsewhere.
        for (int i = 0; i < 256; i++) image[i] = 8'($urandom);
        image[8'h00] = 8'h01; image[8'h01] = 8'h85; image[8'h02] = 8'h3C;
        image[8'h03] = 8'h02; image[8'h04] = 8'h90; image[8'h05] = 8'h11;
        image[8'h06] = 8'h03; image[8'h07] = 8'h7F; image[8'h08] = 8'hC0;
        image[8'h09] = 8'h22; image[8'h0A] = 8'h04; image[8'h0B] = 8'h05;
        image[8'h0C] = 8'h06; image[8'hFF] = 8'h8A;

        vecs[0] = '{8'h00, 8'h01, 8'h00, 1'b0, 2};
        vecs[1] = '{8'h01, 8'h85, 8'h3C, 1'b1, 5};
        vecs[2] = '{8'h03, 8'h02, 8'h00, 1'b0, 3};
        vecs[3] = '{8'h04, 8'h90, 8'h11, 1'b1, 5};
        vecs[4] = '{8'h06, 8'h03, 8'h00, 1'b0, 3};
        vecs[5] = '{8'h07, 8'h7F, 8'h00, 1'b0, 3};
        vecs[6] = '{8'h08, 8'hC0, 8'h22, 1'b1, 5};
        vecs[7] = '{8'h0A, 8'h04, 8'h00, 1'b0, 3};

        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        halt = 1'b0; inst_ready = 1'b1;
`ifdef LOADER_PORT_EN
        ld_req = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
`endif
        repeat (3) @(negedge clk);

        // ---- reset values ----
        check("rst_valid", inst_valid, 0);
        check("rst_op", inst_op, 0);
        check("rst_imm", inst_imm, 0);
        check("rst_len", inst_len, 0);
        check("rst_pc", inst_pc, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_din", mem_din, 0);

        // ---- sequential fetch from reset, ready held high ----
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            wait_valid(12, cyc);
            expect_inst($sformatf("seq%0d", i), cyc, vecs[i].lat,
                        vecs[i].pc, vecs[i].op, vecs[i].imm, vecs[i].len);
        end

        // ---- decode back-pressure: outputs and port frozen in OUT ----
        @(negedge clk);
        inst_ready = 1'b0;
        wait_valid(12, cyc);
        expect_inst("stall", cyc, 2, 8'h0B, 8'h05, 8'h00, 1'b0);
        s_op = inst_op; s_pc = inst_pc; s_addr = mem_addr;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", inst_valid, 1);
            check("stall_op", inst_op, s_op);
            check("stall_pc", inst_pc, s_pc);
            check("stall_mem_addr", mem_addr, s_addr);
        end
        inst_ready = 1'b1;
        wait_valid(12, cyc);
        expect_inst("after_stall", cyc, 3, 8'h0C, 8'h06, 8'h00, 1'b0);

        // ---- redirect together with a handshake ----
        redirect = 1'b1; redirect_pc = 8'h07;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid(12, cyc);
        expect_inst("redir_hs", cyc, 2, 8'h07, 8'h7F, 8'h00, 1'b0);

        // ---- redirect in IMM_WAIT to FF: partial dropped, wrap to 00 ----
        redirect = 1'b1; redirect_pc = 8'h01;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);                       // OP_WAIT
        @(negedge clk);                       // IMM_REQ
        check("imm_req_addr", mem_addr, 8'h02);
        @(negedge clk);                       // IMM_WAIT
        check("imm_wait_valid", inst_valid, 0);
        redirect = 1'b1; redirect_pc = 8'hFF;
        @(negedge clk);
        redirect = 1'b0;
        check("redir_ff_addr", mem_addr, 8'hFF);
        check("redir_ff_valid", inst_valid, 0);
        wait_valid(12, cyc);
        expect_inst("wrap", cyc, 4, 8'hFF, 8'h8A, 8'h01, 1'b1);
        wait_valid(12, cyc);
        expect_inst("after_wrap", cyc, 5, 8'h01, 8'h85, 8'h3C, 1'b1);

        // ---- halt raised during OP_WAIT ----
        @(negedge clk);                       // OP_REQ at 03
        @(negedge clk);                       // OP_WAIT
        halt = 1'b1;
        wait_valid(12, cyc);
        expect_inst("halt_inflight", cyc, 1, 8'h03, 8'h02, 8'h00, 1'b0);
        repeat (6) begin
            @(negedge clk);
            check("halted_valid", inst_valid, 0);
            check("halted_addr", mem_addr, 8'h04);
        end
        redirect = 1'b1; redirect_pc = 8'h06;
        @(negedge clk);
        redirect = 1'b0;
        check("halted_redir_addr", mem_addr, 8'h06);
        @(negedge clk);
        check("halted_redir_valid", inst_valid, 0);
        halt = 1'b0;
        wait_valid(12, cyc);
        expect_inst("resume", cyc, 2, 8'h06, 8'h03, 8'h00, 1'b0);

        // ---- asynchronous reset in IMM_WAIT ----
        redirect = 1'b1; redirect_pc = 8'h01;
        @(negedge clk);
        redirect = 1'b0;
        repeat (3) @(negedge clk);            // OP_WAIT, IMM_REQ, IMM_WAIT
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", inst_valid, 0);
        check("arst_op", inst_op, 0);
        check("arst_len", inst_len, 0);
        check("arst_imm", inst_imm, 0);
        check("arst_pc", inst_pc, 0);
        check("arst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(12, cyc);
        expect_inst("restart", cyc, 2, 8'h00, 8'h01, 8'h00, 1'b0);

`ifdef LOADER_PORT_EN
        // ---- loader write in OP_REQ, then fetch the written byte ----
        @(negedge clk);                       // OP_REQ at 01
        ld_req = 1'b1; ld_addr = 8'h10; ld_data = 8'hAA;
        #1;
        check("ld_gnt", ld_gnt, 1);
        check("ld_we", mem_we, 1);
        check("ld_addr", mem_addr, 8'h10);
        check("ld_din", mem_din, 8'hAA);
        @(negedge clk);
        ld_req = 1'b0;
        check("ld_hold_addr", mem_addr, 8'h01);
        check("ld_done_we", mem_we, 0);
        wait_valid(12, cyc);
        expect_inst("ld_stalled", cyc, 4, 8'h01, 8'h85, 8'h3C, 1'b1);
        redirect = 1'b1; redirect_pc = 8'h10;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid(12, cyc);
        expect_inst("ld_fetch", cyc, 4, 8'h10, 8'hAA, mem_rd(8'h11), 1'b1);
`endif

        // ---- randomized ready/redirect against an instruction-level model ----
        redirect = 1'b1; redirect_pc = 8'h20;
        @(negedge clk);
        redirect = 1'b0;
        m_pc = 8'h20; seen = 1'b0; since = 1;
        for (int n = 0; n < 3000; n++) begin
            e_op  = mem_rd(m_pc);
            e_len = e_op[7];
            e_imm = e_len ? mem_rd(m_pc + 8'd1) : 8'h00;
            if (inst_valid) begin
                if (!seen) check("rnd_lat", since, 3 + 2 * int'(e_len));
                seen = 1'b1;
                check("rnd_pc", inst_pc, m_pc);
                check("rnd_op", inst_op, e_op);
                check("rnd_imm", inst_imm, e_imm);
                check("rnd_len", inst_len, e_len);
                check("rnd_addr", mem_addr, m_pc);
            end else if (!seen && since > 5) begin
                checks++;
                errors++;
                $display("FAIL rnd_no_valid: pc %0h waited %0d cycles", m_pc, since);
                seen = 1'b1;
            end
            inst_ready  = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 8'($urandom);
            hs = inst_valid && inst_ready;
            if (redirect)  m_pc = redirect_pc;
            else if (hs)   m_pc = m_pc + (e_len ? 8'd2 : 8'd1);
            if (redirect || hs) begin
                seen  = 1'b0;
                since = 0;
            end
            @(negedge clk);
            since++;
        end
        redirect = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
